// File: rtl/spi_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_ctrl_pkg
// Description : Shared types, command codes and CRC-8 helper for the SPI
//               frame controller.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_LEN       = 3'd2,
        ST_WDATA     = 3'd3,
        ST_RD_REQ    = 3'd4,
        ST_RD_WAIT   = 3'd5,
        ST_RD_STREAM = 3'd6,
        ST_DRAIN     = 3'd7
    } state_t;

    localparam logic [7:0] CMD_WRITE    = 8'h01;
    localparam logic [7:0] CMD_READ     = 8'h02;
    localparam logic [7:0] TIMEOUT_DATA = 8'hFF;
    localparam logic [7:0] CRC8_POLY    = 8'h07;

    // One byte of MSB-first CRC-8 folded into the running value.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_ctrl_crc8.sv
`default_nettype none
// ============================================================================
// Module      : spi_ctrl_crc8
// Description : Running CRC-8 (poly 0x07, init 0x00) over read-data bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_ctrl_crc8
    import spi_ctrl_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clear,
    input  logic       i_enable,
    input  logic [7:0] i_byte,
    output logic [7:0] o_crc
);

    logic [7:0] r_crc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_crc <= 8'h00;
        end else if (i_clear) begin
            r_crc <= 8'h00;
        end else if (i_enable) begin
            r_crc <= crc8_byte(r_crc, i_byte);
        end
    end

    assign o_crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/spi_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_frame_ctrl
// Description : Parses CS-framed SPI transactions (CMD, ADDR, LEN, data) into
//               register-bus writes/reads; read data returns via tx load.
//               Optional read CRC trailer: define SPI_CTRL_RDCRC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_frame_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int ACK_TIMEOUT = 64,
    parameter int CNT_W       = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    input  logic              i_busy,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    output logic [ADDR_W-1:0] o_reg_addr,
    output logic [7:0]        o_reg_wdata,
    output logic              o_reg_wr,
    output logic              o_reg_rd,
    input  logic [7:0]        i_reg_rdata,
    input  logic              i_reg_ack,
    output logic              o_frame_err
);

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    state_t              r_state, w_state;
    logic [ADDR_W-1:0]   r_addr, w_addr;
    logic [CNT_W-1:0]    r_rem, w_rem;
    logic                r_is_read, w_is_read;
    logic [TMO_W-1:0]    r_tmo, w_tmo;
    logic [ADDR_W-1:0]   r_reg_addr, w_reg_addr;
    logic [7:0]          r_wdata, w_wdata;
    logic [7:0]          r_tx_data, w_tx_data;
    logic                r_tx_valid, w_tx_valid;
    logic                r_wr, w_wr;
    logic                r_rd, w_rd;
    logic                r_err, w_err;

`ifdef SPI_CTRL_RDCRC_EN
    logic                w_crc_clr;
    logic                w_crc_en;
    logic [7:0]          w_crc;

    spi_ctrl_crc8 u_crc8 (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (w_crc_clr),
        .i_enable (w_crc_en),
        .i_byte   (i_reg_rdata),
        .o_crc    (w_crc)
    );
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_rem      <= '0;
            r_is_read  <= 1'b0;
            r_tmo      <= '0;
            r_reg_addr <= '0;
            r_wdata    <= 8'h00;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_wr       <= 1'b0;
            r_rd       <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_addr     <= w_addr;
            r_rem      <= w_rem;
            r_is_read  <= w_is_read;
            r_tmo      <= w_tmo;
            r_reg_addr <= w_reg_addr;
            r_wdata    <= w_wdata;
            r_tx_data  <= w_tx_data;
            r_tx_valid <= w_tx_valid;
            r_wr       <= w_wr;
            r_rd       <= w_rd;
            r_err      <= w_err;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_addr     = r_addr;
        w_rem      = r_rem;
        w_is_read  = r_is_read;
        w_tmo      = r_tmo;
        w_reg_addr = r_reg_addr;
        w_wdata    = r_wdata;
        w_tx_data  = r_tx_data;
        w_tx_valid = 1'b0;
        w_wr       = 1'b0;
        w_rd       = 1'b0;
        w_err      = 1'b0;
`ifdef SPI_CTRL_RDCRC_EN
        w_crc_clr  = 1'b0;
        w_crc_en   = 1'b0;
`endif

        // CS release ends the frame and outranks any byte arriving with it.
        if (r_state != ST_IDLE && !i_busy) begin
            w_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_rx_valid && i_busy) begin
                        if (i_rx_data == CMD_WRITE || i_rx_data == CMD_READ) begin
                            w_is_read = (i_rx_data == CMD_READ);
                            w_state   = ST_ADDR;
                        end else begin
                            w_err   = 1'b1;
                            w_state = ST_DRAIN;
                        end
                    end
                end
                ST_ADDR: begin
                    if (i_rx_valid) begin
                        w_addr  = ADDR_W'(i_rx_data);
                        w_state = ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (i_rx_valid) begin
                        w_rem = CNT_W'(i_rx_data);
`ifdef SPI_CTRL_RDCRC_EN
                        w_crc_clr = 1'b1;
`endif
                        if (i_rx_data == 8'h00) begin
                            w_state = ST_DRAIN;
                        end else if (r_is_read) begin
                            w_state = ST_RD_REQ;
                        end else begin
                            w_state = ST_WDATA;
                        end
                    end
                end
                ST_WDATA: begin
                    if (i_rx_valid) begin
                        w_wr       = 1'b1;
                        w_wdata    = i_rx_data;
                        w_reg_addr = r_addr;
                        w_addr     = r_addr + ADDR_W'(1);
                        w_rem      = r_rem - CNT_W'(1);
                        if (r_rem == CNT_W'(1)) begin
                            w_state = ST_DRAIN;
                        end
                    end
                end
                ST_RD_REQ: begin
                    w_rd       = 1'b1;
                    w_reg_addr = r_addr;
                    w_tmo      = '0;
                    w_state    = ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (i_reg_ack) begin
                        w_tx_data  = i_reg_rdata;
                        w_tx_valid = 1'b1;
                        w_addr     = r_addr + ADDR_W'(1);
                        w_rem      = r_rem - CNT_W'(1);
`ifdef SPI_CTRL_RDCRC_EN
                        w_crc_en   = 1'b1;
`endif
                        w_state    = ST_RD_STREAM;
                    end else if (r_tmo == TMO_W'(ACK_TIMEOUT - 1)) begin
                        w_tx_data  = TIMEOUT_DATA;
                        w_tx_valid = 1'b1;
                        w_err      = 1'b1;
                        w_state    = ST_DRAIN;
                    end else begin
                        w_tmo = r_tmo + TMO_W'(1);
                    end
                end
                ST_RD_STREAM: begin
                    // The master's dummy byte has shifted the loaded data out.
                    if (i_rx_valid) begin
                        if (r_rem != '0) begin
                            w_state = ST_RD_REQ;
                        end else begin
`ifdef SPI_CTRL_RDCRC_EN
                            w_tx_data  = w_crc;
                            w_tx_valid = 1'b1;
`endif
                            w_state = ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    w_state = ST_DRAIN;
                end
                default: begin
                    w_state = ST_IDLE;
                end
            endcase
        end
    end

    assign o_tx_data   = r_tx_data;
    assign o_tx_valid  = r_tx_valid;
    assign o_reg_addr  = r_reg_addr;
    assign o_reg_wdata = r_wdata;
    assign o_reg_wr    = r_wr;
    assign o_reg_rd    = r_rd;
    assign o_frame_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_frame_ctrl
// Description : Directed self-checking bench for spi_frame_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_frame_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata;
    logic       reg_ack;
    logic       frame_err;

    int checks   = 0;
    int failures = 0;

    logic [7:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    logic [7:0] rd_addr_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] rdata_q[$];
    int         err_cnt  = 0;
    int         overlap  = 0;
    int         cyc      = 0;
    int         rd_cyc   = 0;
    int         tx_cyc   = 0;
    logic       ack_en   = 1'b1;

    spi_frame_ctrl #(.ADDR_W(8), .ACK_TIMEOUT(64), .CNT_W(8)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .i_busy      (busy),
        .o_tx_data   (tx_data),
        .o_tx_valid  (tx_valid),
        .o_reg_addr  (reg_addr),
        .o_reg_wdata (reg_wdata),
        .o_reg_wr    (reg_wr),
        .o_reg_rd    (reg_rd),
        .i_reg_rdata (reg_rdata),
        .i_reg_ack   (reg_ack),
        .o_frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event recorder, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (reg_wr) begin
            wr_addr_q.push_back(reg_addr);
            wr_data_q.push_back(reg_wdata);
        end
        if (reg_rd) begin
            rd_addr_q.push_back(reg_addr);
            rd_cyc = cyc;
        end
        if (tx_valid) begin
            tx_q.push_back(tx_data);
            tx_cyc = cyc;
        end
        if (frame_err) err_cnt++;
        if (reg_wr && reg_rd) overlap++;
    end

    // Register-bus responder: ack one cycle after the read strobe is seen.
    always @(negedge clk) begin
        if (reg_rd && ack_en) begin
            @(posedge clk);
            #1;
            reg_rdata = (rdata_q.size() > 0) ? rdata_q.pop_front() : 8'h00;
            reg_ack   = 1'b1;
            @(posedge clk);
            #1;
            reg_ack   = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        repeat (8) step();
    endtask

    task automatic end_frame();
        busy = 1'b0;
        repeat (3) step();
    endtask

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
        tx_q.delete();
        err_cnt = 0;
    endtask

    initial begin
        rst_n     = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        busy      = 1'b0;
        reg_rdata = 8'h00;
        reg_ack   = 1'b0;
        repeat (3) step();
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_reg_wr",   32'(reg_wr),   32'h0);
        chk("rst_reg_rd",   32'(reg_rd),   32'h0);
        chk("rst_addr",     32'(reg_addr), 32'h0);
        chk("rst_err",      32'(frame_err), 32'h0);
        rst_n = 1'b1;
        repeat (2) step();

        // Write frame
        clear_logs();
        busy = 1'b1;
        step();
        send_byte(8'h01); send_byte(8'h10); send_byte(8'h03);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
        end_frame();
        chk("wr_count", 32'(wr_addr_q.size()), 32'd3);
        if (wr_addr_q.size() == 3) begin
            chk("wr0_addr", 32'(wr_addr_q[0]), 32'h10);
            chk("wr0_data", 32'(wr_data_q[0]), 32'hAA);
            chk("wr1_addr", 32'(wr_addr_q[1]), 32'h11);
            chk("wr1_data", 32'(wr_data_q[1]), 32'hBB);
            chk("wr2_addr", 32'(wr_addr_q[2]), 32'h12);
            chk("wr2_data", 32'(wr_data_q[2]), 32'hCC);
        end
        chk("wr_no_err", 32'(err_cnt), 32'd0);
        chk("wr_no_rd",  32'(rd_addr_q.size()), 32'd0);

        // Read frame with address wrap
        clear_logs();
        rdata_q = '{8'h11, 8'h22, 8'h33};
        busy = 1'b1;
        step();
        send_byte(8'h02); send_byte(8'hFE); send_byte(8'h03);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        end_frame();
        chk("rd_count", 32'(rd_addr_q.size()), 32'd3);
        if (rd_addr_q.size() == 3) begin
            chk("rd0_addr", 32'(rd_addr_q[0]), 32'hFE);
            chk("rd1_addr", 32'(rd_addr_q[1]), 32'hFF);
            chk("rd2_addr", 32'(rd_addr_q[2]), 32'h00);
        end
`ifdef SPI_CTRL_RDCRC_EN
        chk("rd_tx_count", 32'(tx_q.size()), 32'd4);
`else
        chk("rd_tx_count", 32'(tx_q.size()), 32'd3);
`endif
        if (tx_q.size() >= 3) begin
            chk("rd_tx0", 32'(tx_q[0]), 32'h11);
            chk("rd_tx1", 32'(tx_q[1]), 32'h22);
            chk("rd_tx2", 32'(tx_q[2]), 32'h33);
        end
        chk("rd_no_err", 32'(err_cnt), 32'd0);

        // Bad command, then a normal frame
        clear_logs();
        busy = 1'b1;
        step();
        send_byte(8'h7F);
        for (int i = 0; i < 5; i++) send_byte(8'h01 + 8'(i));
        chk("bad_err_count", 32'(err_cnt), 32'd1);
        chk("bad_no_wr", 32'(wr_addr_q.size()), 32'd0);
        chk("bad_no_rd", 32'(rd_addr_q.size()), 32'd0);
        end_frame();
        busy = 1'b1;
        step();
        send_byte(8'h01); send_byte(8'h30); send_byte(8'h01); send_byte(8'h55);
        end_frame();
        chk("bad_next_wr_count", 32'(wr_addr_q.size()), 32'd1);
        if (wr_addr_q.size() == 1) begin
            chk("bad_next_addr", 32'(wr_addr_q[0]), 32'h30);
            chk("bad_next_data", 32'(wr_data_q[0]), 32'h55);
        end
        chk("bad_next_err", 32'(err_cnt), 32'd1);

        // Read timeout
        clear_logs();
        ack_en = 1'b0;
        busy = 1'b1;
        step();
        send_byte(8'h02); send_byte(8'h40); send_byte(8'h02);
        for (int i = 0; i < 200 && tx_q.size() == 0; i++) step();
        chk("tmo_tx_seen", 32'(tx_q.size()), 32'd1);
        if (tx_q.size() == 1) begin
            chk("tmo_tx_data", 32'(tx_q[0]), 32'hFF);
            chk("tmo_latency", 32'(tx_cyc - rd_cyc), 32'd64);
        end
        send_byte(8'h00); send_byte(8'h00);
        repeat (20) step();
        chk("tmo_err", 32'(err_cnt), 32'd1);
        chk("tmo_rd_count", 32'(rd_addr_q.size()), 32'd1);
        end_frame();
        ack_en = 1'b1;

        // Abort mid-write; the byte arriving with CS release is dropped
        clear_logs();
        busy = 1'b1;
        step();
        send_byte(8'h01); send_byte(8'h20); send_byte(8'h04);
        send_byte(8'h01); send_byte(8'h02);
        rx_data  = 8'h03;
        rx_valid = 1'b1;
        busy     = 1'b0;
        step();
        rx_valid = 1'b0;
        repeat (3) step();
        chk("abort_wr_count", 32'(wr_addr_q.size()), 32'd2);
        if (wr_addr_q.size() == 2) begin
            chk("abort_wr1_addr", 32'(wr_addr_q[1]), 32'h21);
            chk("abort_wr1_data", 32'(wr_data_q[1]), 32'h02);
        end
        clear_logs();
        busy = 1'b1;
        step();
        send_byte(8'h01); send_byte(8'h50); send_byte(8'h01); send_byte(8'h77);
        end_frame();
        chk("abort_next_count", 32'(wr_addr_q.size()), 32'd1);
        if (wr_addr_q.size() == 1) begin
            chk("abort_next_addr", 32'(wr_addr_q[0]), 32'h50);
            chk("abort_next_data", 32'(wr_data_q[0]), 32'h77);
        end
        chk("no_overlap", 32'(overlap), 32'd0);

        // Asynchronous reset while waiting for an ack
        clear_logs();
        ack_en = 1'b0;
        busy = 1'b1;
        step();
        send_byte(8'h02); send_byte(8'h60); send_byte(8'h01);
        chk("arst_pre_addr", 32'(reg_addr), 32'h60);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_addr",  32'(reg_addr),  32'h0);
        chk("arst_tx",    32'(tx_data),   32'h0);
        chk("arst_txv",   32'(tx_valid),  32'h0);
        chk("arst_rd",    32'(reg_rd),    32'h0);
        chk("arst_err",   32'(frame_err), 32'h0);
        busy = 1'b0;
        step();
        rst_n = 1'b1;
        ack_en = 1'b1;
        repeat (2) step();

`ifdef SPI_CTRL_RDCRC_EN
        // Read with CRC trailer
        clear_logs();
        rdata_q = '{8'h01, 8'h02};
        busy = 1'b1;
        step();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        end_frame();
        chk("crc_tx_count", 32'(tx_q.size()), 32'd3);
        if (tx_q.size() == 3) begin
            chk("crc_tx0", 32'(tx_q[0]), 32'h01);
            chk("crc_tx1", 32'(tx_q[1]), 32'h02);
            chk("crc_value", 32'(tx_q[2]), 32'h1B);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
